// File: rtl/sys_cmd_pkg.sv
// Shared definitions for the UART command host: frame headers, command
// encodings, FSM states and per-command length lookups.
package sys_cmd_pkg;

   localparam logic [7:0] HDR_RF_WR     = 8'hAA;
   localparam logic [7:0] HDR_RF_RD     = 8'hBB;
   localparam logic [7:0] HDR_ALU_W_OP  = 8'hCC;
   localparam logic [7:0] HDR_ALU_NO_OP = 8'hDD;

   typedef enum logic [1:0] {
      OP_RF_WR     = 2'd0,
      OP_RF_RD     = 2'd1,
      OP_ALU_W_OP  = 2'd2,
      OP_ALU_NO_OP = 2'd3
   } cmd_op_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SEND     = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_DONE     = 2'd3
   } state_e;

   // Index of the last frame byte (frame length minus one).
   function automatic logic [1:0] frame_last_idx(input cmd_op_e op);
      case (op)
         OP_RF_WR:    frame_last_idx = 2'd2;
         OP_RF_RD:    frame_last_idx = 2'd1;
         OP_ALU_W_OP: frame_last_idx = 2'd3;
         default:     frame_last_idx = 2'd1;
      endcase
   endfunction

   // Number of response bytes the target returns for a command.
   function automatic logic [1:0] rsp_len(input cmd_op_e op);
      case (op)
         OP_RF_WR: rsp_len = 2'd0;
         OP_RF_RD: rsp_len = 2'd1;
         default:  rsp_len = 2'd2;
      endcase
   endfunction

endpackage

// File: rtl/sys_cmd_timer.sv
// Inter-byte response timer: counts idle cycles while enabled, clears on
// request, flags the cycle in which the count sits at TIMEOUT_CYC-1.
module sys_cmd_timer
   import sys_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 65535,
   parameter int unsigned TMR_W       = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [TMR_W-1:0] TC_VAL = TMR_W'(TIMEOUT_CYC - 1);

   logic [TMR_W-1:0] cnt_q;

   // Counter: clear has priority over enable.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + TMR_W'(1);
      end
   end

   assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/sys_cmd_host.sv
// Host-side command initiator: builds a frame from one command, streams it
// to the UART TX byte interface, collects the response bytes from UART RX
// and reports the result with a single RSP_VALID pulse.
module sys_cmd_host
   import sys_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 65535,
   parameter int unsigned TMR_W       = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CMD_VALID,
   output logic        CMD_READY,
   input  logic [1:0]  CMD_OP,
   input  logic [7:0]  CMD_ADDR,
   input  logic [7:0]  CMD_DATA,
   input  logic [7:0]  CMD_OPA,
   input  logic [7:0]  CMD_OPB,
   input  logic [3:0]  CMD_FUN,
   output logic [7:0]  TX_BYTE,
   output logic        TX_VALID,
   input  logic        TX_READY,
   input  logic [7:0]  RX_BYTE,
   input  logic        RX_VALID,
   output logic        RSP_VALID,
   output logic [15:0] RSP_DATA,
   output logic        RSP_TIMEOUT,
   output logic        BUSY
);

   state_e      state_q, state_d;
   logic [7:0]  buf_q [4];
   logic [7:0]  buf_d [4];
   logic [7:0]  frm   [4];
   logic [1:0]  last_idx_q, last_idx_d;
   logic [1:0]  rsp_len_q, rsp_len_d;
   logic [1:0]  tx_idx_q, tx_idx_d;
   logic [1:0]  rx_cnt_q, rx_cnt_d;
   logic        tx_valid_q, tx_valid_d;
   logic [7:0]  tx_byte_q, tx_byte_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [15:0] rsp_data_q, rsp_data_d;
   logic        rsp_to_q, rsp_to_d;
   logic        tmr_clr, tmr_en, tmr_tc;

   sys_cmd_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .TMR_W       (TMR_W)
   ) u_timer (
      .clk_i (CLK),
      .rst_i (RST),
      .clr_i (tmr_clr),
      .en_i  (tmr_en),
      .tc_o  (tmr_tc)
   );

   // Frame image for the command currently on the request inputs.
   always_comb begin
      frm[0] = 8'h00;
      frm[1] = 8'h00;
      frm[2] = 8'h00;
      frm[3] = 8'h00;
      case (cmd_op_e'(CMD_OP))
         OP_RF_WR: begin
            frm[0] = HDR_RF_WR;
            frm[1] = CMD_ADDR;
            frm[2] = CMD_DATA;
         end
         OP_RF_RD: begin
            frm[0] = HDR_RF_RD;
            frm[1] = CMD_ADDR;
         end
         OP_ALU_W_OP: begin
            frm[0] = HDR_ALU_W_OP;
            frm[1] = CMD_OPA;
            frm[2] = CMD_OPB;
            frm[3] = {4'h0, CMD_FUN};
         end
         default: begin
            frm[0] = HDR_ALU_NO_OP;
            frm[1] = {4'h0, CMD_FUN};
         end
      endcase
   end

   // Next-state and registered-output logic for the command FSM.
   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      last_idx_d  = last_idx_q;
      rsp_len_d   = rsp_len_q;
      tx_idx_d    = tx_idx_q;
      rx_cnt_d    = rx_cnt_q;
      tx_valid_d  = tx_valid_q;
      tx_byte_d   = tx_byte_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_to_d    = rsp_to_q;
      tmr_clr     = 1'b0;
      tmr_en      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (CMD_VALID) begin
               buf_d      = frm;
               last_idx_d = frame_last_idx(cmd_op_e'(CMD_OP));
               rsp_len_d  = rsp_len(cmd_op_e'(CMD_OP));
               tx_idx_d   = 2'd0;
               tx_valid_d = 1'b1;
               tx_byte_d  = frm[0];
               rsp_data_d = 16'h0000;
               rsp_to_d   = 1'b0;
               state_d    = ST_SEND;
            end
         end
         ST_SEND: begin
            if (TX_READY) begin
               if (tx_idx_q == last_idx_q) begin
                  tx_valid_d = 1'b0;
                  if (rsp_len_q == 2'd0) begin
                     rsp_valid_d = 1'b1;
                     state_d     = ST_DONE;
                  end else begin
                     tmr_clr  = 1'b1;
                     rx_cnt_d = 2'd0;
                     state_d  = ST_WAIT_RSP;
                  end
               end else begin
                  tx_idx_d  = tx_idx_q + 2'd1;
                  tx_byte_d = buf_q[tx_idx_q + 2'd1];
               end
            end
         end
         ST_WAIT_RSP: begin
            // A byte arriving on the terminal-count cycle still counts.
            if (RX_VALID) begin
               if (rx_cnt_q == 2'd0) begin
                  rsp_data_d[7:0] = RX_BYTE;
               end else begin
                  rsp_data_d[15:8] = RX_BYTE;
               end
               rx_cnt_d = rx_cnt_q + 2'd1;
               tmr_clr  = 1'b1;
               if ((rx_cnt_q + 2'd1) == rsp_len_q) begin
                  rsp_valid_d = 1'b1;
                  state_d     = ST_DONE;
               end
            end else if (tmr_tc) begin
               rsp_to_d    = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               tmr_en = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Frame buffer holds data only, so it needs no reset.
   always_ff @(posedge CLK) begin
      buf_q <= buf_d;
   end

   // State and control/output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         last_idx_q  <= 2'd0;
         rsp_len_q   <= 2'd0;
         tx_idx_q    <= 2'd0;
         rx_cnt_q    <= 2'd0;
         tx_valid_q  <= 1'b0;
         tx_byte_q   <= 8'h00;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 16'h0000;
         rsp_to_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_idx_q  <= last_idx_d;
         rsp_len_q   <= rsp_len_d;
         tx_idx_q    <= tx_idx_d;
         rx_cnt_q    <= rx_cnt_d;
         tx_valid_q  <= tx_valid_d;
         tx_byte_q   <= tx_byte_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_to_q    <= rsp_to_d;
      end
   end

   assign CMD_READY   = (state_q == ST_IDLE);
   assign BUSY        = (state_q != ST_IDLE);
   assign TX_VALID    = tx_valid_q;
   assign TX_BYTE     = tx_byte_q;
   assign RSP_VALID   = rsp_valid_q;
   assign RSP_DATA    = rsp_data_q;
   assign RSP_TIMEOUT = rsp_to_q;

endmodule

// File: tb/tb_sys_cmd_host.sv
// Self-checking bench for sys_cmd_host: table of commands with expected
// frames and responses, scoreboard queues for TX bytes and responses.
module tb_sys_cmd_host;

   localparam int TO_CYC = 16;
   localparam int NV     = 8;

   logic        CLK, RST;
   logic        CMD_VALID, CMD_READY;
   logic [1:0]  CMD_OP;
   logic [7:0]  CMD_ADDR, CMD_DATA, CMD_OPA, CMD_OPB;
   logic [3:0]  CMD_FUN;
   logic [7:0]  TX_BYTE;
   logic        TX_VALID, TX_READY;
   logic [7:0]  RX_BYTE;
   logic        RX_VALID;
   logic        RSP_VALID;
   logic [15:0] RSP_DATA;
   logic        RSP_TIMEOUT;
   logic        BUSY;

   sys_cmd_host #(.TIMEOUT_CYC(TO_CYC), .TMR_W(5)) dut (
      .CLK(CLK), .RST(RST),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
      .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .CMD_OPA(CMD_OPA),
      .CMD_OPB(CMD_OPB), .CMD_FUN(CMD_FUN),
      .TX_BYTE(TX_BYTE), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
      .RX_BYTE(RX_BYTE), .RX_VALID(RX_VALID),
      .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_TIMEOUT(RSP_TIMEOUT),
      .BUSY(BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [1:0]  op;
      logic [7:0]  addr, data, opa, opb;
      logic [3:0]  fun;
      int          stall;
      bit          stray;
      logic [31:0] tx;
      int          ntx;
      logic [15:0] rx;
      int          nrx;
      int          gap;
      logic [15:0] exp_data;
      bit          exp_to;
      int          exp_lat;
   } vec_t;

   vec_t        tbl [NV];
   logic [7:0]  exp_tx_q [$];
   logic [16:0] exp_rsp_q [$];
   int          errors = 0;
   int          checks = 0;
   int          stall_cfg = 0;
   int          scnt = 0;
   bit          stall_chk = 0;
   logic [7:0]  held_byte = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] data,
                               input logic [7:0] opa, input logic [7:0] opb, input logic [3:0] fun,
                               input int stall, input bit stray, input logic [31:0] tx, input int ntx,
                               input logic [15:0] rx, input int nrx, input int gap,
                               input logic [15:0] exp_data, input bit exp_to, input int exp_lat);
      vec_t v;
      v.op = op; v.addr = addr; v.data = data; v.opa = opa; v.opb = opb; v.fun = fun;
      v.stall = stall; v.stray = stray; v.tx = tx; v.ntx = ntx; v.rx = rx; v.nrx = nrx;
      v.gap = gap; v.exp_data = exp_data; v.exp_to = exp_to; v.exp_lat = exp_lat;
      return v;
   endfunction

   // TX_READY model: hold ready low for stall_cfg cycles per offered byte.
   initial begin
      TX_READY = 1'b1;
      forever begin
         @(posedge CLK);
         #1;
         if (TX_READY) scnt = 0;
         if (TX_VALID && scnt < stall_cfg) begin
            TX_READY = 1'b0;
            scnt++;
         end else begin
            TX_READY = 1'b1;
         end
      end
   end

   // Monitor: scoreboard TX bytes and responses, check stall stability.
   always @(negedge CLK) begin
      if (RST) begin
         stall_chk = 0;
      end else begin
         if (stall_chk) begin
            chk("tx_stall_valid", {31'd0, TX_VALID}, 32'd1);
            chk("tx_stall_byte", {24'd0, TX_BYTE}, {24'd0, held_byte});
         end
         stall_chk = TX_VALID && !TX_READY;
         held_byte = TX_BYTE;
         if (TX_VALID && TX_READY) begin
            if (exp_tx_q.size() == 0) begin
               chk("tx_unexpected", {24'd0, TX_BYTE}, 32'hFFFF_FFFF);
            end else begin
               chk("tx_byte", {24'd0, TX_BYTE}, {24'd0, exp_tx_q.pop_front()});
            end
         end
         if (RSP_VALID) begin
            if (exp_rsp_q.size() == 0) begin
               chk("rsp_unexpected", {15'd0, RSP_TIMEOUT, RSP_DATA}, 32'hFFFF_FFFF);
            end else begin
               chk("rsp_to_data", {15'd0, RSP_TIMEOUT, RSP_DATA}, {15'd0, exp_rsp_q.pop_front()});
            end
         end
      end
   end

   task automatic pulse_rx(input logic [7:0] b);
      RX_BYTE  = b;
      RX_VALID = 1'b1;
      @(posedge CLK); #1;
      RX_VALID = 1'b0;
      RX_BYTE  = 8'h00;
   endtask

   task automatic wait_ready(input int idx);
      int n = 0;
      while (!CMD_READY && n < 60) begin
         @(posedge CLK); #1;
         n++;
      end
      chk($sformatf("v%0d_cmd_ready", idx), {31'd0, CMD_READY}, 32'd1);
   endtask

   task automatic drive_cmd(input vec_t v);
      CMD_OP = v.op; CMD_ADDR = v.addr; CMD_DATA = v.data;
      CMD_OPA = v.opa; CMD_OPB = v.opb; CMD_FUN = v.fun;
      CMD_VALID = 1'b1;
      @(posedge CLK); #1;
      CMD_VALID = 1'b0;
      CMD_OP = 2'($urandom_range(0, 3)); CMD_ADDR = 8'($urandom); CMD_DATA = 8'($urandom);
      CMD_OPA = 8'($urandom); CMD_OPB = 8'($urandom); CMD_FUN = 4'($urandom);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int n;
      wait_ready(idx);
      if (v.stray) pulse_rx(8'hEE);
      stall_cfg = v.stall;
      for (int i = 0; i < v.ntx; i++) exp_tx_q.push_back(v.tx[8*i +: 8]);
      exp_rsp_q.push_back({v.exp_to, v.exp_data});
      drive_cmd(v);
      chk($sformatf("v%0d_busy", idx), {31'd0, BUSY}, 32'd1);
      chk($sformatf("v%0d_ready_low", idx), {31'd0, CMD_READY}, 32'd0);
      chk($sformatf("v%0d_rsp_cleared", idx), {15'd0, RSP_TIMEOUT, RSP_DATA}, 32'd0);
      if (v.stray) pulse_rx(8'hEE);
      n = 0;
      while (TX_VALID && n < 200) begin
         @(posedge CLK); #1;
         n++;
      end
      chk($sformatf("v%0d_tx_done", idx), {31'd0, TX_VALID}, 32'd0);
      for (int i = 0; i < v.nrx; i++) begin
         repeat (v.gap) begin @(posedge CLK); #1; end
         pulse_rx(v.rx[8*i +: 8]);
      end
      n = 0;
      while (!RSP_VALID && n < 60) begin
         @(posedge CLK); #1;
         n++;
      end
      chk($sformatf("v%0d_latency", idx), n, v.exp_lat);
      chk($sformatf("v%0d_txq_empty", idx), exp_tx_q.size(), 32'd0);
      @(posedge CLK); #1;
      chk($sformatf("v%0d_rsp_pulse_1cyc", idx), {31'd0, RSP_VALID}, 32'd0);
      chk($sformatf("v%0d_rsp_held", idx), {15'd0, RSP_TIMEOUT, RSP_DATA}, {15'd0, v.exp_to, v.exp_data});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      //           op    addr   data   opa    opb    fun   stl stray tx            ntx rx        nrx gap exp      to lat
      tbl[0] = mk(2'd0, 8'h04, 8'h5A, 8'h00, 8'h00, 4'h0, 0, 0, 32'h005A04AA, 3, 16'h0000, 0, 0, 16'h0000, 0, 0);
      tbl[1] = mk(2'd1, 8'h02, 8'h00, 8'h00, 8'h00, 4'h0, 5, 0, 32'h000002BB, 2, 16'h0081, 1, 0, 16'h0081, 0, 0);
      tbl[2] = mk(2'd2, 8'h00, 8'h00, 8'h0F, 8'h03, 4'h0, 0, 0, 32'h00030FCC, 4, 16'h0012, 2, 0, 16'h0012, 0, 0);
      tbl[3] = mk(2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 4'h2, 0, 0, 32'h000002DD, 2, 16'h0034, 1, 0, 16'h0034, 1, 16);
      tbl[4] = mk(2'd1, 8'h07, 8'h00, 8'h00, 8'h00, 4'h0, 0, 1, 32'h000007BB, 2, 16'h0011, 1, 0, 16'h0011, 0, 0);
      tbl[5] = mk(2'd2, 8'h00, 8'h00, 8'hA5, 8'h5A, 4'hB, 1, 0, 32'h0B5AA5CC, 4, 16'h1234, 2, 0, 16'h1234, 0, 0);
      tbl[6] = mk(2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF, 0, 0, 32'h00000FDD, 2, 16'h0000, 0, 0, 16'h0000, 1, 16);
      tbl[7] = mk(2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 4'h1, 0, 0, 32'h000001DD, 2, 16'h7856, 2, 15, 16'h7856, 0, 0);

      RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = 2'd0; CMD_ADDR = 8'h00; CMD_DATA = 8'h00;
      CMD_OPA = 8'h00; CMD_OPB = 8'h00; CMD_FUN = 4'h0; RX_BYTE = 8'h00; RX_VALID = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      chk("rst_tx_valid", {31'd0, TX_VALID}, 32'd0);
      chk("rst_tx_byte", {24'd0, TX_BYTE}, 32'd0);
      chk("rst_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
      chk("rst_rsp", {15'd0, RSP_TIMEOUT, RSP_DATA}, 32'd0);
      chk("rst_busy", {31'd0, BUSY}, 32'd0);
      chk("rst_cmd_ready", {31'd0, CMD_READY}, 32'd1);

      for (int i = 0; i < NV; i++) run_vec(tbl[i], i);

      // Reset in the middle of an ALU_W_OP frame, after its second byte.
      wait_ready(90);
      stall_cfg = 0;
      exp_tx_q.push_back(8'hCC);
      exp_tx_q.push_back(8'h0F);
      drive_cmd(tbl[2]);
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      chk("abort_tx_valid", {31'd0, TX_VALID}, 32'd0);
      chk("abort_tx_byte", {24'd0, TX_BYTE}, 32'd0);
      chk("abort_busy", {31'd0, BUSY}, 32'd0);
      chk("abort_cmd_ready", {31'd0, CMD_READY}, 32'd1);
      chk("abort_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
      RST = 1'b0;
      chk("abort_txq_empty", exp_tx_q.size(), 32'd0);
      repeat (20) @(posedge CLK);
      #1;
      run_vec(tbl[0], 91);
      run_vec(tbl[1], 92);

      repeat (5) @(posedge CLK);
      #1;
      chk("end_rspq_empty", exp_rsp_q.size(), 32'd0);
      chk("end_txq_empty", exp_tx_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
